// File: rtl/blk_11ee36.sv
// Signed WIDTH x WIDTH multiplier using Karatsuba with one shared shift-add unit.
// Optional macro K_ZERO_SKIP_EN: a zero operand skips the partial products.
module blk_11ee36 #(
  parameter int WIDTH = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic [WIDTH-1:0]   Multiplicand,
  input  logic [WIDTH-1:0]   Multiplier,
  output logic [2*WIDTH-1:0] Product,
  output logic               Done
);

  localparam int HALF = WIDTH / 2;
  localparam int PW   = HALF + 1;
  localparam int AW   = 2 * PW;
  localparam int PRW  = 2 * WIDTH;
  localparam int CW   = $clog2(PW);
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MUL_Z0,
    MUL_Z2,
    MUL_Z1,
    COMBINE
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic              sign;
  logic [HALF-1:0]   a_hi;
  logic [HALF-1:0]   b_hi;
  logic [PW-1:0]     sa;
  logic [PW-1:0]     sb;
  logic [AW-1:0]     acc;
  logic [AW-1:0]     mcand;
  logic [PW-1:0]     mplier;
  logic [CW-1:0]     cnt;
  logic [AW-1:0]     z0;
  logic [AW-1:0]     z2;
  logic [AW-1:0]     p1;

  logic [WIDTH-1:0]  abs_a;
  logic [WIDTH-1:0]  abs_b;
  logic [AW-1:0]     acc_next;
  logic [AW-1:0]     z1;
  logic [PRW-1:0]    mag;
  logic [PRW-1:0]    result;
  logic              zero_skip;

  // Negating the most negative value wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
  assign abs_a    = a_reg[WIDTH-1] ? -a_reg : a_reg;
  assign abs_b    = b_reg[WIDTH-1] ? -b_reg : b_reg;
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign z1       = p1 - z2 - z0;
  assign mag      = (PRW'(z2) << WIDTH) + (PRW'(z1) << HALF) + PRW'(z0);
  assign result   = sign ? -mag : mag;

`ifdef K_ZERO_SKIP_EN
  assign zero_skip = (a_reg == '0) || (b_reg == '0);
`else
  assign zero_skip = 1'b0;
`endif

  // Sequencer plus shift-add datapath: one multiplier bit consumed per cycle.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      sign    <= 1'b0;
      a_hi    <= '0;
      b_hi    <= '0;
      sa      <= '0;
      sb      <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      z0      <= '0;
      z2      <= '0;
      p1      <= '0;
      Product <= '0;
      Done    <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            a_reg <= Multiplicand;
            b_reg <= Multiplier;
            state <= LOAD;
          end
        end
        LOAD: begin
          sign   <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
          a_hi   <= abs_a[WIDTH-1:HALF];
          b_hi   <= abs_b[WIDTH-1:HALF];
          sa     <= PW'(abs_a[WIDTH-1:HALF]) + PW'(abs_a[HALF-1:0]);
          sb     <= PW'(abs_b[WIDTH-1:HALF]) + PW'(abs_b[HALF-1:0]);
          mcand  <= AW'(abs_a[HALF-1:0]);
          mplier <= PW'(abs_b[HALF-1:0]);
          acc    <= '0;
          cnt    <= '0;
          z0     <= '0;
          z2     <= '0;
          p1     <= '0;
          state  <= zero_skip ? COMBINE : MUL_Z0;
        end
        MUL_Z0, MUL_Z2, MUL_Z1: begin
          if (cnt == CNT_LAST) begin
            acc <= '0;
            cnt <= '0;
            case (state)
              MUL_Z0: begin
                z0     <= acc_next;
                mcand  <= AW'(a_hi);
                mplier <= PW'(b_hi);
                state  <= MUL_Z2;
              end
              MUL_Z2: begin
                z2     <= acc_next;
                mcand  <= AW'(sa);
                mplier <= sb;
                state  <= MUL_Z1;
              end
              default: begin
                p1    <= acc_next;
                state <= COMBINE;
              end
            endcase
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
          end
        end
        COMBINE: begin
          Product <= result;
          Done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blk_11ee36.sv
// Self-checking bench for blk_11ee36: directed corner cases, abort/ignore scenarios
// and random back-to-back products checked against plain integer multiplication.
module tb_blk_11ee36;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [15:0] Multiplicand;
  logic [15:0] Multiplier;
  logic [31:0] Product;
  logic        Done;

  int n_compared;
  int n_failed;

  blk_11ee36 #(.WIDTH(16)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Start        (Start),
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .Product      (Product),
    .Done         (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [31:0] ref_product(input logic [15:0] a, input logic [15:0] b);
    longint pa;
    longint pb;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    return 32'(pa * pb);
  endfunction

  function automatic int ref_latency(input logic [15:0] a, input logic [15:0] b);
`ifdef K_ZERO_SKIP_EN
    if (a == 16'd0 || b == 16'd0) return 2;
`endif
    return 29;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected)
    else begin
      n_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Counts edges until Done is seen (sampled 1 time unit after each edge); -1 if budget expires.
  task automatic waitDone(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge Clock);
      #1;
      if (Done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic countDone(input int cycles, output int hits);
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge Clock);
      #1;
      if (Done) hits++;
    end
  endtask

  // Issues one operation, scrambles the inputs after capture, then checks latency and result.
  task automatic applyStimulus(input string tag, input logic [15:0] a, input logic [15:0] b);
    int lat;
    Multiplicand = a;
    Multiplier   = b;
    Start        = 1'b1;
    @(posedge Clock);
    #1;
    Start        = 1'b0;
    Multiplicand = 16'($urandom);
    Multiplier   = 16'($urandom);
    waitDone(40, lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(ref_latency(a, b)));
    checkOutput({tag, "_product"}, Product, ref_product(a, b));
  endtask

  initial begin
    int lat;
    int hits;
    logic [15:0] ra;
    logic [15:0] rb;

    n_compared   = 0;
    n_failed     = 0;
    Reset        = 1'b0;
    Start        = 1'b0;
    Multiplicand = '0;
    Multiplier   = '0;

    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    checkOutput("reset_product", Product, 32'd0);
    checkOutput("reset_done", 32'(Done), 32'd0);

    applyStimulus("small", 16'd12, 16'd10);
    applyStimulus("zero_b", 16'd150, 16'd0);
    applyStimulus("times_two", 16'd150, 16'd2);
    applyStimulus("byte_range", 16'd255, 16'd250);

    countDone(12, hits);
    checkOutput("hold_done", 32'(hits), 32'd0);
    checkOutput("hold_product", Product, 32'd63750);

    applyStimulus("neg_pos", 16'hFFF9, 16'd5);
    checkOutput("neg_pos_literal", Product, 32'hFFFFFFDD);
    applyStimulus("min_min", 16'h8000, 16'h8000);
    checkOutput("min_min_literal", Product, 32'h40000000);
    applyStimulus("max_min", 16'h7FFF, 16'h8000);
    checkOutput("max_min_literal", Product, 32'hC0008000);
    applyStimulus("zero_a_neg", 16'd0, 16'hFFFB);

    // Second Start mid-operation must be ignored.
    Multiplicand = 16'd100;
    Multiplier   = 16'hFFFD;
    Start        = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    repeat (9) @(posedge Clock);
    #1;
    Multiplicand = 16'd7;
    Multiplier   = 16'd7;
    Start        = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    waitDone(40, lat);
    checkOutput("busy_start_latency", 32'(lat + 10), 32'd29);
    checkOutput("busy_start_product", Product, ref_product(16'd100, 16'hFFFD));
    countDone(35, hits);
    checkOutput("busy_start_single_done", 32'(hits), 32'd0);

    // Reset in flight aborts without a Done.
    Multiplicand = 16'd1234;
    Multiplier   = 16'hFDC9;
    Start        = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    repeat (8) @(posedge Clock);
    #1;
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    checkOutput("abort_product", Product, 32'd0);
    checkOutput("abort_done", 32'(Done), 32'd0);
    countDone(35, hits);
    checkOutput("abort_no_done", 32'(hits), 32'd0);
    applyStimulus("after_abort", 16'd1234, 16'hFDC9);

    // Random back-to-back operations; each Start is raised while Done is high.
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i == 5) ra = 16'd0;
      if (i == 9) rb = 16'h8000;
      applyStimulus("random", ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
